gs_divider: RTL

GS_DIVIDER -- requirements
Module: gs_divider

---
 rtl/gs_divider.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gs_divider.sv
// Unsigned integer divider using Goldschmidt iteration on a normalised divisor,
// followed by a one-step remainder correction so the result is exact.
//
// state | meaning
// IDLE  | waiting for start
// NORM  | normalise divisor into [0.5,1), shift dividend by the same amount
// ITER  | Goldschmidt loop, phase 0: n*k, phase 1: d*k and k=2-d
// QUOT  | take integer part of n as quotient estimate
// CORR  | r = a - q_est*b on the shared multiplier
// FIX   | single +/-1 correction of quotient and remainder
// DONE  | results valid for one cycle, new request may be accepted
module gs_divider #(
  parameter int WIDTH = 16,
  parameter int ITERS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int FW = 2*WIDTH + 2;
  localparam int NW = WIDTH + FW;
  localparam int KW = FW + 1;
  localparam int PW = NW + KW;
  localparam int LW = $clog2(WIDTH);
  localparam int CW = $clog2(ITERS) + 1;
  localparam logic [KW:0]   TWO    = {2'b10, {FW{1'b0}}};
  localparam logic [KW-1:0] K_SEED = {2'b11, {(FW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, NORM, ITER, QUOT, CORR, FIX, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [NW-1:0]      n;
  logic [KW-1:0]      d, k;
  logic               phase;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   q_est;
  logic [WIDTH+1:0]   r_acc;

  logic [LW-1:0]      s;
  logic [WIDTH-1:0]   b_norm;
  logic [2*WIDTH-1:0] a_norm;
  logic [NW-1:0]      mul_a;
  logic [KW-1:0]      mul_b;
  logic [PW-1:0]      prod;
  logic [NW-1:0]      n_mul;
  logic [KW-1:0]      d_mul;
  logic [KW:0]        two_minus;
  logic [WIDTH+1:0]   r_calc;
  logic [WIDTH+1:0]   b_ext;
  logic               unused_bits;

  function automatic logic [LW-1:0] lead_zeros(input logic [WIDTH-1:0] v);
    lead_zeros = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) lead_zeros = LW'(WIDTH - 1 - i);
  endfunction

  always_comb s = lead_zeros(b_reg);
  assign b_norm = b_reg << s;
  assign a_norm = {{WIDTH{1'b0}}, a_reg} << s;

  // One multiplier shared by the loop (n*k, d*k) and the remainder step (q_est*b)
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == ITER) begin
      mul_a = phase ? NW'(d) : n;
      mul_b = k;
    end else if (state == CORR) begin
      mul_a = NW'(q_est);
      mul_b = KW'(b_reg);
    end
  end

  assign prod      = PW'(mul_a) * PW'(mul_b);
  assign n_mul     = prod[FW +: NW];
  assign d_mul     = prod[FW +: KW];
  assign two_minus = TWO - {1'b0, d_mul};
  assign b_ext     = {2'b00, b_reg};
  assign r_calc    = {2'b00, a_reg} - prod[WIDTH+1:0];
  assign unused_bits = ^{prod, two_minus[KW]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      n           <= '0;
      d           <= '0;
      k           <= '0;
      phase       <= 1'b0;
      cnt         <= '0;
      q_est       <= '0;
      r_acc       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            a_reg <= dividend;
            b_reg <= divisor;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= NORM;
              busy  <= 1'b1;
            end
          end
        end
        NORM: begin
          n     <= {a_norm, {(FW-WIDTH){1'b0}}};
          d     <= {1'b0, b_norm, {(FW-WIDTH){1'b0}}};
          k     <= K_SEED;
          phase <= 1'b0;
          cnt   <= CW'(ITERS - 1);
          state <= ITER;
        end
        ITER: begin
          phase <= ~phase;
          if (!phase) begin
            n <= n_mul;
          end else begin
            d <= d_mul;
            k <= two_minus[KW-1:0];
            if (cnt == '0) state <= QUOT;
            else           cnt   <= cnt - CW'(1);
          end
        end
        QUOT: begin
          q_est <= n[FW +: WIDTH];
          state <= CORR;
        end
        CORR: begin
          r_acc <= r_calc;
          state <= FIX;
        end
        FIX: begin
          if (r_acc[WIDTH+1]) begin
            quotient  <= q_est - WIDTH'(1);
            remainder <= WIDTH'(r_acc + b_ext);
          end else if (r_acc >= b_ext) begin
            quotient  <= q_est + WIDTH'(1);
            remainder <= WIDTH'(r_acc - b_ext);
          end else begin
            quotient  <= q_est;
            remainder <= r_acc[WIDTH-1:0];
          end
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
